// File: rtl/serial_cfg_tx_if.sv
// Handshake and serial-wire bundle for the configuration link transmitter.
// The master is the host that requests transfers; the slave is the transmitter.
interface serial_cfg_tx_if #(
  parameter int unsigned WIDTH = 52
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             sen;
  logic             sclk;
  logic             sdata;

  modport master (
    output start, data_in,
    input  busy, done, sen, sclk, sdata
  );

  modport slave (
    input  start, data_in,
    output busy, done, sen, sclk, sdata
  );
endinterface

// File: rtl/serial_cfg_tx.sv
// Serializes a WIDTH-bit word LSB-first onto sen/sclk/sdata. The sclk phase length
// is chosen so that a receiver behind 3-flop synchronizers sees every edge.
module serial_cfg_tx #(
  parameter int unsigned WIDTH       = 52,
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_cfg_tx_if.slave   bus
);
  localparam int unsigned PW = $clog2(HALF_PERIOD);
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, TRAIL, GAP} state_t;

  state_t           state;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    idx;
  logic [WIDTH-1:0] sh;
  logic             sen_r;
  logic             sclk_r;
  logic             sdata_r;
  logic             busy_r;
  logic             done_r;
  logic             phase_end;

  assign phase_end = (phase == PW'(HALF_PERIOD - 1));

  assign bus.sen   = sen_r;
  assign bus.sclk  = sclk_r;
  assign bus.sdata = sdata_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

  // sh holds the bits still to be sent after the one currently on sdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      idx     <= '0;
      sh      <= '0;
      sen_r   <= 1'b0;
      sclk_r  <= 1'b0;
      sdata_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh      <= {1'b0, bus.data_in[WIDTH-1:1]};
            sdata_r <= bus.data_in[0];
            idx     <= '0;
            phase   <= '0;
            sen_r   <= 1'b1;
            sclk_r  <= 1'b0;
            busy_r  <= 1'b1;
            state   <= LOW;
          end
        end
        LOW: begin
          if (phase_end) begin
            phase  <= '0;
            sclk_r <= 1'b1;
            state  <= HIGH;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        HIGH: begin
          if (phase_end) begin
            phase  <= '0;
            sclk_r <= 1'b0;
            // Data moves on the falling edge so it is stable across the next rise.
            if (idx != BW'(WIDTH - 1)) begin
              sdata_r <= sh[0];
              sh      <= {1'b0, sh[WIDTH-1:1]};
              idx     <= idx + BW'(1);
              state   <= LOW;
            end else begin
              sdata_r <= 1'b0;
              state   <= TRAIL;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        TRAIL: begin
          if (phase_end) begin
            phase  <= '0;
            sen_r  <= 1'b0;
            done_r <= 1'b1;
            state  <= GAP;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        GAP: begin
          if (phase_end) begin
            phase  <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_cfg_tx.sv
// Directed bench for serial_cfg_tx: frame timing, synchronized-receiver data
// recovery, start/reset corner cases and a WIDTH=2 instance.
module tb_serial_cfg_tx;
  localparam int unsigned W  = 52;
  localparam int unsigned HP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_cfg_tx_if #(.WIDTH(W)) bus ();
  serial_cfg_tx_if #(.WIDTH(2)) bus2 ();

  serial_cfg_tx #(.WIDTH(W), .HALF_PERIOD(HP)) dut  (.clk(clk), .rst(rst), .bus(bus));
  serial_cfg_tx #(.WIDTH(2), .HALF_PERIOD(HP)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame monitor for the main instance, sampled on the falling edge.
  logic p_sen = 1'b0, p_sclk = 1'b0, p_sdata = 1'b0, p_busy = 1'b0;
  int sen_run = 0, sen_len = 0, rises = 0, rise_bad = 0, dones = 0, done_bad = 0;
  int sdata_bad = 0, gap_run = 0, busy_gap = 0, low_run = 0, low_len = 0;
  int frames = 0, total_dones = 0;
  logic [2:0] ss_sen = '0, ss_sclk = '0, ss_sdata = '0;
  logic ss_sen_d = 1'b0, ss_sclk_d = 1'b0;
  logic [W-1:0] rx = '0, rx_word = '0;

  always @(negedge clk) begin
    if (bus.sen === 1'b1 && !p_sen) begin
      frames++;
      low_len  = low_run;
      sen_run  = 0;
      rises    = 0;
      rise_bad = 0;
      dones    = 0;
      done_bad = 0;
    end
    if (bus.sen === 1'b1) sen_run++;
    if (bus.sen === 1'b0 && p_sen) begin
      sen_len = sen_run;
      gap_run = 0;
      low_run = 1;
    end else if (bus.sen === 1'b0) begin
      gap_run++;
      low_run++;
    end
    if (bus.busy === 1'b0 && p_busy) busy_gap = gap_run;
    if (bus.sclk === 1'b1 && !p_sclk) begin
      if (sen_run != int'(HP + 1 + 2 * HP * rises)) rise_bad++;
      rises++;
    end
    if (bus.sclk === 1'b1 && bus.sdata !== p_sdata) sdata_bad++;
    if (bus.done === 1'b1) begin
      dones++;
      total_dones++;
      if (!(bus.sen === 1'b0 && p_sen)) done_bad++;
    end
    // Receiver model: 3-flop synchronizers, shift on sync'd sclk rise.
    ss_sen   = {ss_sen[1:0], bus.sen};
    ss_sclk  = {ss_sclk[1:0], bus.sclk};
    ss_sdata = {ss_sdata[1:0], bus.sdata};
    if (ss_sclk[2] === 1'b1 && !ss_sclk_d && ss_sen[2] === 1'b1) rx = {ss_sdata[2], rx[W-1:1]};
    if (ss_sen[2] === 1'b0 && ss_sen_d) rx_word = rx;
    ss_sclk_d = (ss_sclk[2] === 1'b1);
    ss_sen_d  = (ss_sen[2] === 1'b1);
    p_sen   = (bus.sen === 1'b1);
    p_sclk  = (bus.sclk === 1'b1);
    p_sdata = bus.sdata;
    p_busy  = (bus.busy === 1'b1);
  end

  // Direct-sampling monitor for the WIDTH=2 instance.
  logic p2_sen = 1'b0, p2_sclk = 1'b0;
  int len2_run = 0, len2 = 0, rises2 = 0;
  logic [1:0] rx2 = '0;

  always @(negedge clk) begin
    if (bus2.sen === 1'b1 && !p2_sen) begin
      len2_run = 0;
      rises2   = 0;
    end
    if (bus2.sen === 1'b1) len2_run++;
    if (bus2.sen === 1'b0 && p2_sen) len2 = len2_run;
    if (bus2.sclk === 1'b1 && !p2_sclk && bus2.sen === 1'b1) begin
      rx2 = {bus2.sdata, rx2[1]};
      rises2++;
    end
    p2_sen  = (bus2.sen === 1'b1);
    p2_sclk = (bus2.sclk === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, "_idle_timeout"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic start_frame(input logic [W-1:0] d);
    bus.start   = 1'b1;
    bus.data_in = d;
    tick();
    bus.start   = 1'b0;
    bus.data_in = W'({$urandom(), $urandom()});
  endtask

  task automatic check_frame(input string tag, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    check({tag, "_sen_len"},   64'(sen_len),   64'(420));
    check({tag, "_rises"},     64'(rises),     64'(52));
    check({tag, "_rise_time"}, 64'(rise_bad),  64'(0));
    check({tag, "_done_cnt"},  64'(dones),     64'(1));
    check({tag, "_done_time"}, 64'(done_bad),  64'(0));
    check({tag, "_busy_gap"},  64'(busy_gap),  64'(4));
    check({tag, "_sdata_hold"}, 64'(sdata_bad), 64'(0));
    check({tag, "_rx_word"},   64'(rx_word),   64'(d));
  endtask

  initial begin
    logic [W-1:0] pat [3];
    logic [W-1:0] d0;
    int f0;
    int dn0;
    int n;

    bus.start    = 1'b0;
    bus.data_in  = '0;
    bus2.start   = 1'b0;
    bus2.data_in = '0;

    // Reset with start held high: nothing may start.
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus2.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outputs", 64'({bus.sen, bus.sclk, bus.sdata, bus.busy, bus.done}), 64'(0));
    end
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus2.start = 1'b0;
    tick();
    check("post_reset_idle", 64'({bus.sen, bus.busy}), 64'(0));

    // Single frame with both end bits set.
    start_frame(52'h8_0000_0000_0001);
    check("accept_outputs", 64'({bus.busy, bus.sen, bus.sclk, bus.sdata, bus.done}), 64'(5'b11010));
    wait_idle("single");
    check_frame("single", 52'h8_0000_0000_0001);

    // Back-to-back pattern sweep.
    pat[0] = 52'hA_AAAA_AAAA_AAAA;
    pat[1] = 52'h5_5555_5555_5555;
    pat[2] = W'({$urandom(), $urandom()});
    for (int k = 0; k < 3; k++) begin
      start_frame(pat[k]);
      wait_idle("sweep");
      check_frame("sweep", pat[k]);
      check("sweep_sen_low", 64'(low_len), 64'(5));
    end

    // start hammered during a frame with changing data.
    tick();
    f0 = frames;
    d0 = 52'h1_2345_6789_ABCD;
    start_frame(d0);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      bus.start   = 1'b1;
      bus.data_in = W'({$urandom(), $urandom()});
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("hammer_timeout", 64'(bus.busy), 64'(0));
    check_frame("hammer", d0);
    for (int i = 0; i < 20; i++) tick();
    check("hammer_one_frame", 64'(frames - f0), 64'(1));
    check("hammer_idle", 64'({bus.sen, bus.busy}), 64'(0));

    // Mid-frame reset abort, then a full frame.
    dn0 = total_dones;
    start_frame(52'hF_0F0F_0F0F_0F0F);
    for (int i = 0; i < 99; i++) tick();
    rst = 1'b1;
    tick();
    check("abort_outputs", 64'({bus.sen, bus.sclk, bus.sdata, bus.busy, bus.done}), 64'(0));
    rst = 1'b0;
    tick();
    tick();
    check("abort_no_done", 64'(total_dones - dn0), 64'(0));
    start_frame(52'h3_C3C3_C3C3_C3C3);
    wait_idle("resend");
    check_frame("resend", 52'h3_C3C3_C3C3_C3C3);

    // WIDTH=2 instance.
    bus2.start   = 1'b1;
    bus2.data_in = 2'b10;
    tick();
    bus2.start   = 1'b0;
    bus2.data_in = 2'b01;
    n = 0;
    while (bus2.busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check("w2_idle_timeout", 64'(bus2.busy), 64'(0));
    @(negedge clk);
    #1;
    check("w2_sen_len", 64'(len2), 64'(20));
    check("w2_rises", 64'(rises2), 64'(2));
    check("w2_rx_word", 64'(rx2), 64'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
